// File: rtl/icache_axi_bridge.sv
// Bridges icache line-read misses onto a single 8-beat AXI INCR read burst.
// Optional last-line buffer (tag + valid hit path) enabled by ICACHE_LINE_BUFFER_EN.
module icache_axi_bridge #(
    parameter logic [3:0]  AXI_ID     = 4'h0,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_req,
    input  logic [31:0]               rd_addr,
    output logic                      ret_valid,
    output logic [LINE_WORDS*32-1:0]  ret_data,
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int unsigned LINE_BITS = LINE_WORDS * 32;
    localparam logic [2:0]  LAST_BEAT = 3'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [26:0]            addr_q, addr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   wd_q, wd_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   ret_valid_q, ret_valid_d;
    logic [LINE_BITS-1:0]   data_q, data_d;
    logic                   beat_c;
    logic                   hit_c;
`ifdef ICACHE_LINE_BUFFER_EN
    logic [26:0]            tag_q, tag_d;
    logic                   tag_valid_q, tag_valid_d;
`endif

    // Burst-end sideband and the line offset bits carry no information here.
    logic unused_c;
    assign unused_c = ^{rid, rresp, rlast, rd_addr[4:0]};

    assign beat_c = rvalid & rready_q;

`ifdef ICACHE_LINE_BUFFER_EN
    assign hit_c = tag_valid_q && (tag_q == rd_addr[31:5]);
`else
    assign hit_c = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        data_d      = data_q;
`ifdef ICACHE_LINE_BUFFER_EN
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = 3'd0;
                wd_d  = 1'b0;
                if (rd_req) begin
                    addr_d  = rd_addr[31:5];
                    state_d = hit_c ? S_RESP : S_AR;
                end
            end
            S_AR: begin
                // A withdrawal seen while AR waits is remembered until arready.
                if (!rd_req) wd_d = 1'b1;
                if (arready) begin
                    cnt_d   = 3'd0;
                    state_d = (wd_q || !rd_req) ? S_DRAIN : S_R;
                end
            end
            S_R, S_DRAIN: begin
                if (beat_c) begin
                    data_d[{cnt_q, 5'b0} +: 32] = rdata;
                    cnt_d = cnt_q + 3'd1;
                end
                if (beat_c && (cnt_q == LAST_BEAT)) begin
                    state_d = ((state_q == S_R) && rd_req) ? S_RESP : S_IDLE;
`ifdef ICACHE_LINE_BUFFER_EN
                    tag_d       = addr_q;
                    tag_valid_d = 1'b1;
`endif
                end else if ((state_q == S_R) && !rd_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        arvalid_d   = (state_d == S_AR);
        rready_d    = (state_d == S_R) || (state_d == S_DRAIN);
        ret_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            wd_q        <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ret_valid_q <= 1'b0;
            data_q      <= '0;
`ifdef ICACHE_LINE_BUFFER_EN
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            ret_valid_q <= ret_valid_d;
            data_q      <= data_d;
`ifdef ICACHE_LINE_BUFFER_EN
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
`endif
        end
    end

    assign arid      = AXI_ID;
    assign araddr    = {addr_q, 5'b0};
    assign arlen     = 8'(LINE_WORDS - 1);
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign ret_valid = ret_valid_q;
    assign ret_data  = data_q;

endmodule
